hazard_sequencer: RTL and testbench

- Pipeline control block for the 5-stage MIPS core. Sits beside the operand-forwarding logic and covers the hazards forwarding cannot resolve.
- Decides each cycle whether IF/ID advances, stalls, or is flushed, and whether ID/EX receives a bubble. Causes: load-use dependence, EX-stage redirect (taken branch/jump), HI/LO interlock.
- Sequences the multi-cycle mult/div unit with a latency counter.
- Keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_sequencer_if.sv | 33 +++
 rtl/hazard_sequencer.sv | 46 ++++
 tb/tb_hazard_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sequencer_if.sv
// hazard_sequencer_if: ID/EX hazard inputs and pipeline control outputs of the hazard sequencer
interface hazard_sequencer_if #(parameter int PERF_W = 32);
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic id_uses_rs;
  logic id_uses_rt;
  logic id_reads_hilo;
  logic idex_mem_read;
  logic [4:0] idex_rt;
  logic ex_redirect;
  logic ex_muldiv_start;
  logic ex_is_div;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble;
  logic muldiv_start;
  logic muldiv_done;
  logic hilo_busy;
  logic [PERF_W-1:0] stall_cycles;
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo, idex_mem_read, idex_rt,
           ex_redirect, ex_muldiv_start, ex_is_div,
    input pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_start, muldiv_done, hilo_busy,
          stall_cycles
  );
  modport slave (
    input id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo, idex_mem_read, idex_rt,
          ex_redirect, ex_muldiv_start, ex_is_div,
    output pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_start, muldiv_done, hilo_busy,
           stall_cycles
  );
endinterface

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: load-use/redirect/HI-LO pipeline control and mult/div latency sequencing
module hazard_sequencer #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 6,
  parameter int PERF_W = 32
) (
  input logic clk,
  input logic rst,
  hazard_sequencer_if.slave h
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [PERF_W-1:0] perf;
  logic load_use, start, stall;
  assign load_use = h.idex_mem_read && h.idex_rt != 5'd0 &&
                    ((h.id_uses_rs && h.id_rs == h.idex_rt) || (h.id_uses_rt && h.id_rt == h.idex_rt));
  assign start = h.ex_muldiv_start && state == IDLE;
  // redirect wins: the ID instruction is squashed, so its hazards are moot
  assign stall = !h.ex_redirect && (load_use || (h.id_reads_hilo && (state == BUSY || start)));
  assign h.pc_write = !rst && (h.ex_redirect || !stall);
  assign h.ifid_write = !rst && (h.ex_redirect || !stall);
  assign h.ifid_flush = rst || h.ex_redirect;
  assign h.idex_bubble = rst || h.ex_redirect || stall;
  assign h.muldiv_start = !rst && start;
  assign h.muldiv_done = !rst && state == BUSY && cnt == '0;
  assign h.hilo_busy = !rst && state == BUSY;
  assign h.stall_cycles = perf;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      perf <= '0;
    end else begin
      if (stall && !(&perf)) perf <= perf + 1'b1;
      if (start) begin
        state <= BUSY;
        cnt <= h.ex_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
      end else if (state == BUSY) begin
        if (cnt == '0) state <= IDLE;
        else cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: table vectors, directed multi-cycle sequences and random run vs a reference model
module tb_hazard_sequencer;
  localparam int MULT_N = 4;
  localparam int DIV_N = 32;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  hazard_sequencer_if #(.PERF_W(32)) h();
  hazard_sequencer_if #(.PERF_W(4)) hs();
  hazard_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6), .PERF_W(32))
    dut (.clk(clk), .rst(rst), .h(h));
  hazard_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6), .PERF_W(4))
    dut_s (.clk(clk), .rst(rst), .h(hs));
  assign hs.id_rs = h.id_rs;
  assign hs.id_rt = h.id_rt;
  assign hs.id_uses_rs = h.id_uses_rs;
  assign hs.id_uses_rt = h.id_uses_rt;
  assign hs.id_reads_hilo = h.id_reads_hilo;
  assign hs.idex_mem_read = h.idex_mem_read;
  assign hs.idex_rt = h.idex_rt;
  assign hs.ex_redirect = h.ex_redirect;
  assign hs.ex_muldiv_start = h.ex_muldiv_start;
  assign hs.ex_is_div = h.ex_is_div;
  always #5 clk = ~clk;

  // reference model: remaining busy cycles and an unbounded stall tally
  int busy_left = 0;
  longint perf = 0;
  bit m_stall, m_start;

  typedef struct {
    bit mr; bit [4:0] irt; bit [4:0] rs; bit [4:0] rt;
    bit urs; bit urt; bit hilo; bit redir;
    bit [3:0] exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic clear_in();
    h.id_rs = 0; h.id_rt = 0; h.id_uses_rs = 0; h.id_uses_rt = 0; h.id_reads_hilo = 0;
    h.idex_mem_read = 0; h.idex_rt = 0; h.ex_redirect = 0; h.ex_muldiv_start = 0; h.ex_is_div = 0;
  endtask

  task automatic look();
    bit lu, hz;
    @(negedge clk);
    lu = h.idex_mem_read && h.idex_rt != 0 &&
         ((h.id_uses_rs && h.id_rs == h.idex_rt) || (h.id_uses_rt && h.id_rt == h.idex_rt));
    m_start = h.ex_muldiv_start && busy_left == 0;
    hz = h.id_reads_hilo && (busy_left > 0 || m_start);
    m_stall = !h.ex_redirect && (lu || hz);
    if (rst) begin
      chk("pc_write", h.pc_write, 0);
      chk("ifid_write", h.ifid_write, 0);
      chk("ifid_flush", h.ifid_flush, 1);
      chk("idex_bubble", h.idex_bubble, 1);
      chk("muldiv_start", h.muldiv_start, 0);
      chk("muldiv_done", h.muldiv_done, 0);
      chk("hilo_busy", h.hilo_busy, 0);
    end else begin
      chk("pc_write", h.pc_write, h.ex_redirect || !m_stall);
      chk("ifid_write", h.ifid_write, h.ex_redirect || !m_stall);
      chk("ifid_flush", h.ifid_flush, h.ex_redirect);
      chk("idex_bubble", h.idex_bubble, h.ex_redirect || m_stall);
      chk("muldiv_start", h.muldiv_start, m_start);
      chk("muldiv_done", h.muldiv_done, busy_left == 1);
      chk("hilo_busy", h.hilo_busy, busy_left > 0);
    end
    chk("stall_cycles", h.stall_cycles, perf > 32'hffff_ffff ? 32'hffff_ffff : 32'(perf));
    chk("stall_cycles_sat", 32'(hs.stall_cycles), perf > 15 ? 15 : 32'(perf));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      busy_left = 0;
      perf = 0;
    end else begin
      if (m_stall) perf++;
      if (m_start) busy_left = h.ex_is_div ? DIV_N : MULT_N;
      else if (busy_left > 0) busy_left--;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    look();
    step();
    rst = 0;
  endtask

  initial begin
    int n, rel, nb, nd;
    clear_in();
    tbl[0] = '{1, 8, 8, 0, 1, 0, 0, 0, 4'b0001};
    tbl[1] = '{1, 0, 0, 0, 1, 0, 0, 0, 4'b1100};
    tbl[2] = '{1, 5, 3, 5, 0, 1, 0, 0, 4'b0001};
    tbl[3] = '{1, 9, 9, 2, 0, 1, 0, 0, 4'b1100};
    tbl[4] = '{0, 8, 8, 0, 1, 0, 0, 0, 4'b1100};
    tbl[5] = '{1, 8, 8, 0, 1, 0, 0, 1, 4'b1111};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 4'b1111};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 1, 0, 4'b1100};
    do_reset();
    look();
    chk("reset_stall_cycles", h.stall_cycles, 0);
    chk("reset_hilo_busy", h.hilo_busy, 0);
    step();
    for (int i = 0; i < 8; i++) begin
      h.idex_mem_read = tbl[i].mr; h.idex_rt = tbl[i].irt; h.id_rs = tbl[i].rs; h.id_rt = tbl[i].rt;
      h.id_uses_rs = tbl[i].urs; h.id_uses_rt = tbl[i].urt; h.id_reads_hilo = tbl[i].hilo;
      h.ex_redirect = tbl[i].redir;
      look();
      chk($sformatf("vec%0d_ctl", i), {28'd0, h.pc_write, h.ifid_write, h.ifid_flush, h.idex_bubble},
          {28'd0, tbl[i].exp});
      step();
    end
    look();
    chk("vec_stall_total", h.stall_cycles, 2);
    step();
    // mult: start pulse at t, busy t+1..t+4, done only at t+4
    do_reset();
    h.ex_muldiv_start = 1;
    look();
    chk("mult_start", h.muldiv_start, 1);
    chk("mult_busy_t", h.hilo_busy, 0);
    step();
    h.ex_muldiv_start = 0;
    for (int i = 1; i <= 5; i++) begin
      look();
      chk($sformatf("mult_busy_t%0d", i), h.hilo_busy, i <= 4);
      chk($sformatf("mult_done_t%0d", i), h.muldiv_done, i == 4);
      step();
    end
    // HI/LO interlock across a div
    do_reset();
    h.id_reads_hilo = 1; h.ex_muldiv_start = 1; h.ex_is_div = 1;
    n = 0; rel = -1;
    for (int i = 0; i < 40; i++) begin
      if (i == 1) h.ex_muldiv_start = 0;
      look();
      if (h.pc_write) begin
        rel = i;
        step();
        break;
      end
      n++;
      step();
    end
    chk("hilo_stall_len", n, 33);
    chk("hilo_release", rel, 33);
    look();
    chk("hilo_stall_cycles", h.stall_cycles, 33);
    step();
    // reset at BUSY cycle 10 of a div aborts it
    do_reset();
    h.ex_muldiv_start = 1; h.ex_is_div = 1;
    look();
    step();
    h.ex_muldiv_start = 0;
    for (int i = 1; i < 10; i++) begin look(); step(); end
    rst = 1;
    look();
    chk("rst_flush", h.ifid_flush, 1);
    chk("rst_busy", h.hilo_busy, 0);
    step();
    rst = 0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin look(); nd += h.muldiv_done; step(); end
    chk("abort_no_done", nd, 0);
    h.ex_muldiv_start = 1;
    look();
    step();
    h.ex_muldiv_start = 0;
    nb = 0; nd = 0;
    for (int i = 0; i < 36; i++) begin look(); nb += h.hilo_busy; nd += h.muldiv_done; step(); end
    chk("restart_busy_len", nb, 32);
    chk("restart_done_cnt", nd, 1);
    // saturation of the narrow counter
    do_reset();
    h.idex_mem_read = 1; h.idex_rt = 8; h.id_rs = 8; h.id_uses_rs = 1;
    for (int i = 0; i < 22; i++) begin look(); step(); end
    look();
    chk("sat_small", 32'(hs.stall_cycles), 15);
    chk("sat_wide", h.stall_cycles, 22);
    step();
    // random run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      h.id_rs = 5'($urandom_range(0, 3)); h.id_rt = 5'($urandom_range(0, 3));
      h.idex_rt = 5'($urandom_range(0, 3));
      h.id_uses_rs = 1'($urandom); h.id_uses_rt = 1'($urandom);
      h.idex_mem_read = 1'($urandom);
      h.id_reads_hilo = ($urandom_range(0, 3) == 0);
      h.ex_redirect = ($urandom_range(0, 5) == 0);
      h.ex_muldiv_start = ($urandom_range(0, 7) == 0);
      h.ex_is_div = 1'($urandom);
      look();
      step();
    end
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
